// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA console clear/scroll engine.
// Map geometry, register offsets, the sequencer states and the CFG register layout.
package vga_console_pkg;

    localparam int ROW_WORDS = 20;
    localparam int ROWS      = 30;
    localparam int MAP_WORDS = ROW_WORDS * ROWS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SCR_RD,
        ST_SCR_CAP,
        ST_SCR_WR,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [11:0] REG_CMD    = 12'h000;
    localparam logic [11:0] REG_CFG    = 12'h004;
    localparam logic [11:0] REG_STATUS = 12'h008;

    localparam logic [1:0] MAP_CHAR = 2'b00;
    localparam logic [1:0] MAP_COL  = 2'b01;
    localparam logic [1:0] REG_WIN  = 2'b11;

    // Packed so that it lines up with CFG bits [16:0].
    typedef struct packed {
        logic       ie;
        logic [7:0] fill_col;
        logic [7:0] fill_char;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{ie: 1'b0, fill_col: 8'h0F, fill_char: 8'h20};

    function automatic logic [31:0] map_addr(input logic [1:0] sel, input logic [9:0] word);
        return {18'b0, sel, word, 2'b00};
    endfunction

endpackage

// File: rtl/vga_console_if.sv
// Simple request/response bus shared by the CPU port and the VGA controller port.
// Read data is returned one cycle after a granted read.
interface vga_bus_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input rdata);
    modport slave  (input req, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/vga_console_fsm.sv
// Clear/scroll sequencer: walks the char map then the colour map one word per granted cycle.
// Stalls (grant low) only hold the current access; nothing is skipped or repeated.
module vga_console_fsm
    import vga_console_pkg::*;
#(
    parameter int ROW_WORDS = vga_console_pkg::ROW_WORDS,
    parameter int MAP_WORDS = vga_console_pkg::MAP_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_clear,
    input  logic        start_scroll,
    input  logic        grant,
    input  cfg_t        fill,
    input  logic [31:0] rdata,
    output logic        eng_req,
    output logic        eng_we,
    output logic [31:0] eng_addr,
    output logic [31:0] eng_wdata,
    output logic        busy,
    output logic        done_set
);

    localparam logic [9:0] LAST_WORD   = 10'(MAP_WORDS - 1);
    localparam logic [9:0] LAST_SCROLL = 10'(MAP_WORDS - ROW_WORDS - 1);
    localparam logic [9:0] FILL_FIRST  = 10'(MAP_WORDS - ROW_WORDS);
    localparam logic [9:0] ROW_STEP    = 10'(ROW_WORDS);

    state_t      state_q, state_d;
    logic        map_q, map_d;
    logic [9:0]  word_q, word_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  map_sel;
    logic [31:0] fill_word;
    logic        unused_ie;

    assign unused_ie = fill.ie;
    assign map_sel   = map_q ? MAP_COL : MAP_CHAR;
    assign fill_word = map_q ? {4{fill.fill_col}} : {4{fill.fill_char}};

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            map_q   <= 1'b0;
            word_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through the case leaves a latch behind.
        state_d = state_q;
        map_d   = map_q;
        word_d  = word_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_clear) begin
                    state_d = ST_CLR;
                    map_d   = 1'b0;
                    word_d  = '0;
                end else if (start_scroll) begin
                    state_d = ST_SCR_RD;
                    map_d   = 1'b0;
                    word_d  = '0;
                end
            end
            ST_CLR: begin
                if (grant) begin
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (map_q) state_d = ST_DONE;
                        else       map_d   = 1'b1;
                    end else begin
                        word_d = word_q + 10'd1;
                    end
                end
            end
            ST_SCR_RD:  if (grant) state_d = ST_SCR_CAP;
            ST_SCR_CAP: begin
                buf_d   = rdata;
                state_d = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                if (grant) begin
                    if (word_q == LAST_SCROLL) begin
                        state_d = ST_FILL;
                        word_d  = FILL_FIRST;
                    end else begin
                        state_d = ST_SCR_RD;
                        word_d  = word_q + 10'd1;
                    end
                end
            end
            ST_FILL: begin
                if (grant) begin
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (map_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SCR_RD;
                            map_d   = 1'b1;
                        end
                    end else begin
                        word_d = word_q + 10'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_req   = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        case (state_q)
            ST_CLR, ST_FILL: begin
                eng_req   = 1'b1;
                eng_we    = 1'b1;
                eng_addr  = map_addr(map_sel, word_q);
                eng_wdata = fill_word;
            end
            ST_SCR_RD: begin
                eng_req  = 1'b1;
                eng_addr = map_addr(map_sel, word_q + ROW_STEP);
            end
            ST_SCR_WR: begin
                eng_req   = 1'b1;
                eng_we    = 1'b1;
                eng_addr  = map_addr(map_sel, word_q);
                eng_wdata = buf_q;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done_set = (state_q == ST_DONE);

endmodule

// File: rtl/vga_console_engine.sv
// VGA console engine top: engine registers in the 0x3000 window, CPU-first bus arbiter
// towards the VGA controller, and the registered read-return path.
module vga_console_engine
    import vga_console_pkg::*;
#(
    parameter int ROW_WORDS = vga_console_pkg::ROW_WORDS,
    parameter int ROWS      = vga_console_pkg::ROWS
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    vga_bus_if.slave  cpu,
    vga_bus_if.master vga,
    output logic     irq_o
);

    localparam int MAP_WORDS = ROW_WORDS * ROWS;

    cfg_t        cfg_q;
    logic        done_q;
    logic        map_rd_q, reg_rd_q;
    logic [31:0] reg_rdata_q, reg_val;
    logic        cpu_map, cpu_reg, reg_rd, cmd_wr, cfg_wr;
    logic [11:0] reg_off;
    logic        eng_req, eng_we, busy, done_set;
    logic [31:0] eng_addr, eng_wdata;
    logic        unused_bits;

    assign unused_bits = ^{cpu.addr[31:14], cpu.addr[1:0], cpu.wdata[31:17], cpu.be[3]};

    assign cpu_map = cpu.req && (cpu.addr[13:12] != REG_WIN);
    assign cpu_reg = cpu.req && (cpu.addr[13:12] == REG_WIN);
    assign reg_off = {cpu.addr[11:2], 2'b00};
    assign reg_rd  = cpu_reg && !cpu.we;
    assign cmd_wr  = cpu_reg && cpu.we && (reg_off == REG_CMD) && !busy;
    assign cfg_wr  = cpu_reg && cpu.we && (reg_off == REG_CFG);

    vga_console_fsm #(
        .ROW_WORDS (ROW_WORDS),
        .MAP_WORDS (MAP_WORDS)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_clear  (cmd_wr && cpu.wdata[0]),
        .start_scroll (cmd_wr && cpu.wdata[1]),
        .grant        (!cpu_map),
        .fill         (cfg_q),
        .rdata        (vga.rdata),
        .eng_req      (eng_req),
        .eng_we       (eng_we),
        .eng_addr     (eng_addr),
        .eng_wdata    (eng_wdata),
        .busy         (busy),
        .done_set     (done_set)
    );

    always_comb begin
        reg_val = '0;
        case (reg_off)
            REG_CFG:    reg_val = {15'b0, cfg_q};
            REG_STATUS: reg_val = {30'b0, done_q, busy};
            default:    reg_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q       <= CFG_RESET;
            done_q      <= 1'b0;
            map_rd_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            if (cfg_wr) begin
                if (cpu.be[0]) cfg_q.fill_char <= cpu.wdata[7:0];
                if (cpu.be[1]) cfg_q.fill_col  <= cpu.wdata[15:8];
                if (cpu.be[2]) cfg_q.ie        <= cpu.wdata[16];
            end
            // The sequencer is busy while in DONE, so a CMD write cannot coincide with done_set.
            if (cmd_wr)        done_q <= 1'b0;
            else if (done_set) done_q <= 1'b1;
            map_rd_q    <= cpu_map && !cpu.we;
            reg_rd_q    <= reg_rd;
            reg_rdata_q <= reg_rd ? reg_val : '0;
        end
    end

    always_comb begin
        if (cpu_map) begin
            vga.req   = 1'b1;
            vga.we    = cpu.we;
            vga.be    = cpu.be;
            vga.addr  = cpu.addr;
            vga.wdata = cpu.wdata;
        end else begin
            vga.req   = eng_req;
            vga.we    = eng_we;
            vga.be    = eng_req ? 4'hF : 4'h0;
            vga.addr  = eng_addr;
            vga.wdata = eng_wdata;
        end
    end

    always_comb begin
        if (map_rd_q)      cpu.rdata = vga.rdata;
        else if (reg_rd_q) cpu.rdata = reg_rdata_q;
        else               cpu.rdata = '0;
    end

    assign irq_o = done_q & cfg_q.ie;

endmodule

// File: tb/tb_vga_console_engine.sv
// Directed bench for vga_console_engine with a behavioural VGA controller memory model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vga_console_engine;
    import vga_console_pkg::*;

    localparam logic [31:0] A_CMD    = 32'h0000_3000;
    localparam logic [31:0] A_CFG    = 32'h0000_3004;
    localparam logic [31:0] A_STATUS = 32'h0000_3008;
    localparam logic [31:0] A_SPARE  = 32'h0000_300C;
    localparam int T_CLEAR  = 2 * 600 + 1;
    localparam int T_SCROLL = 2 * (3 * (600 - 20) + 20) + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_bus_if cpu_bus ();
    vga_bus_if vga_bus ();

    vga_console_engine dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cpu    (cpu_bus),
        .vga    (vga_bus),
        .irq_o  (irq)
    );

    // Controller model: word-addressed char map (idx 0..1023) and colour map (1024..2047).
    logic [31:0] vmem [0:2047];
    int unsigned vga_wr_total = 0;

    always @(posedge clk) begin
        if (vga_bus.req) begin
            if (vga_bus.we) begin
                for (int b = 0; b < 4; b++)
                    if (vga_bus.be[b]) vmem[vga_bus.addr[12:2]][8*b +: 8] <= vga_bus.wdata[8*b +: 8];
                vga_wr_total <= vga_wr_total + 1;
            end else begin
                vga_bus.rdata <= vmem[vga_bus.addr[12:2]];
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b1;
        cpu_bus.be    = be;
        cpu_bus.addr  = a;
        cpu_bus.wdata = d;
        @(negedge clk);
        cpu_bus.req = 1'b0;
        cpu_bus.we  = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        cpu_bus.req  = 1'b1;
        cpu_bus.we   = 1'b0;
        cpu_bus.be   = 4'hF;
        cpu_bus.addr = a;
        @(negedge clk);
        cpu_bus.req = 1'b0;
        d = cpu_bus.rdata;
    endtask

    task automatic wait_irq(inout int cnt, input int limit);
        while (!irq && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic preload();
        for (int n = 0; n < 600; n++) begin
            cpu_write(32'(n * 4), 32'(n));
            cpu_write(32'h1000 + 32'(n * 4), 32'h00C0_0000 + 32'(n));
        end
    endtask

    function automatic int clear_errors(input logic mapb, input logic [7:0] fill);
        int bad = 0;
        for (int n = 0; n < 600; n++)
            if (vmem[{mapb, 10'(n)}] !== {4{fill}}) bad++;
        return bad;
    endfunction

    function automatic int scroll_errors(input logic mapb, input logic [7:0] fill);
        int bad = 0;
        logic [31:0] base = mapb ? 32'h00C0_0000 : 32'h0;
        logic [31:0] exp;
        for (int n = 0; n < 600; n++) begin
            exp = (n < 580) ? base + 32'(n + 20) : {4{fill}};
            if (vmem[{mapb, 10'(n)}] !== exp) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        #1;
        n_cmp++;
        if ({vga_bus.req, vga_bus.we, vga_bus.be, vga_bus.addr, vga_bus.wdata} !== '0) begin
            $display("FAIL reset_vga_out: got req=%b addr=%h, want all zero", vga_bus.req, vga_bus.addr);
            n_fail++;
        end
        n_cmp++;
        if (cpu_bus.rdata !== 32'h0) begin
            $display("FAIL reset_cpu_rdata: got %h, want 0", cpu_bus.rdata);
            n_fail++;
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL reset_irq: got %b, want 0", irq);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_read(A_CFG, d);
        n_cmp++;
        if (d !== 32'h0000_0F20) begin
            $display("FAIL reset_cfg: got %h, want 00000f20", d);
            n_fail++;
        end
        cpu_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0) begin
            $display("FAIL reset_status: got %h, want 0", d);
            n_fail++;
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] d;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b1;
        cpu_bus.be    = 4'hF;
        cpu_bus.addr  = 32'h0000_1234;
        cpu_bus.wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({vga_bus.req, vga_bus.we, vga_bus.be, vga_bus.addr, vga_bus.wdata} !==
            {1'b1, 1'b1, 4'hF, 32'h0000_1234, 32'hDEAD_BEEF}) begin
            $display("FAIL pass_write: got req=%b we=%b be=%h addr=%h wdata=%h, want 1 1 f 00001234 deadbeef",
                     vga_bus.req, vga_bus.we, vga_bus.be, vga_bus.addr, vga_bus.wdata);
            n_fail++;
        end
        @(negedge clk);
        cpu_bus.req = 1'b0;
        cpu_read(32'h0000_1234, d);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF) begin
            $display("FAIL pass_read: got %h, want deadbeef", d);
            n_fail++;
        end
        cpu_bus.req  = 1'b1;
        cpu_bus.we   = 1'b0;
        cpu_bus.addr = A_STATUS;
        #1;
        n_cmp++;
        if (vga_bus.req !== 1'b0) begin
            $display("FAIL reg_no_bus: got vga req %b, want 0", vga_bus.req);
            n_fail++;
        end
        @(negedge clk);
        cpu_bus.req = 1'b0;
        cpu_write(A_SPARE, 32'hFFFF_FFFF);
        cpu_read(A_SPARE, d);
        n_cmp++;
        if (d !== 32'h0) begin
            $display("FAIL spare_read: got %h, want 0", d);
            n_fail++;
        end
    endtask

    task automatic test_cfg();
        logic [31:0] d;
        cpu_write(A_CFG, 32'h0001_1E41);
        cpu_read(A_CFG, d);
        n_cmp++;
        if (d !== 32'h0001_1E41) begin
            $display("FAIL cfg_write: got %h, want 00011e41", d);
            n_fail++;
        end
        cpu_write(A_CFG, 32'hFFFF_77FF, 4'b0010);
        cpu_read(A_CFG, d);
        n_cmp++;
        if (d !== 32'h0001_7741) begin
            $display("FAIL cfg_byte_en: got %h, want 00017741", d);
            n_fail++;
        end
        cpu_write(A_CFG, 32'h0001_1E41);
    endtask

    task automatic test_clear();
        int unsigned w0 = vga_wr_total;
        int cnt = 0;
        int bad;
        logic [31:0] d;
        cpu_write(A_CMD, 32'h1);
        wait_irq(cnt, 5000);
        n_cmp++;
        if (cnt !== T_CLEAR) begin
            $display("FAIL clear_cycles: got %0d, want %0d", cnt, T_CLEAR);
            n_fail++;
        end
        n_cmp++;
        if (vga_wr_total - w0 !== 1200) begin
            $display("FAIL clear_writes: got %0d, want 1200", vga_wr_total - w0);
            n_fail++;
        end
        bad = clear_errors(1'b0, 8'h41);
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL clear_char_map: got %0d bad words, want 0", bad);
            n_fail++;
        end
        bad = clear_errors(1'b1, 8'h1E);
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL clear_col_map: got %0d bad words, want 0", bad);
            n_fail++;
        end
        cpu_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h2) begin
            $display("FAIL clear_status: got %h, want 2", d);
            n_fail++;
        end
    endtask

    task automatic test_busy_cmd();
        int cnt = 0;
        logic [31:0] d;
        cpu_write(A_CMD, 32'h1);
        cpu_read(A_STATUS, d);
        cnt++;
        n_cmp++;
        if (d !== 32'h1) begin
            $display("FAIL busy_status: got %h, want 1", d);
            n_fail++;
        end
        cpu_write(A_CMD, 32'h2);
        cnt++;
        cpu_write(A_CMD, 32'h1);
        cnt++;
        wait_irq(cnt, 5000);
        n_cmp++;
        if (cnt !== T_CLEAR) begin
            $display("FAIL busy_no_restart: got %0d cycles, want %0d", cnt, T_CLEAR);
            n_fail++;
        end
        cpu_write(A_CMD, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_drop: got %b, want 0", irq);
            n_fail++;
        end
        cpu_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0) begin
            $display("FAIL done_cleared: got %h, want 0", d);
            n_fail++;
        end
    endtask

    task automatic test_scroll();
        int unsigned w0;
        int cnt = 0;
        int bad;
        preload();
        w0 = vga_wr_total;
        cpu_write(A_CMD, 32'h2);
        wait_irq(cnt, 10000);
        n_cmp++;
        if (cnt !== T_SCROLL) begin
            $display("FAIL scroll_cycles: got %0d, want %0d", cnt, T_SCROLL);
            n_fail++;
        end
        n_cmp++;
        if (vga_wr_total - w0 !== 1200) begin
            $display("FAIL scroll_writes: got %0d, want 1200", vga_wr_total - w0);
            n_fail++;
        end
        bad = scroll_errors(1'b0, 8'h41);
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL scroll_char_map: got %0d bad words, want 0", bad);
            n_fail++;
        end
        bad = scroll_errors(1'b1, 8'h1E);
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL scroll_col_map: got %0d bad words, want 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_contested();
        int cnt = 0;
        int k = 0;
        int bad;
        logic [31:0] a, d, exp;
        preload();
        cpu_write(A_CMD, 32'h2);
        while (!irq && cnt < 20000) begin
            if (cnt % 3 == 0) begin
                a   = 32'((700 + (k / 2) % 300) * 4);
                exp = 32'hA500_0000 + 32'(k / 2);
                if (k % 2 == 0) begin
                    cpu_write(a, exp);
                end else begin
                    cpu_read(a, d);
                    n_cmp++;
                    if (d !== exp) begin
                        $display("FAIL contested_cpu_read: addr %h got %h, want %h", a, d, exp);
                        n_fail++;
                    end
                end
                k++;
            end else begin
                @(negedge clk);
            end
            cnt++;
        end
        n_cmp++;
        if (!(cnt > T_SCROLL && cnt < 20000)) begin
            $display("FAIL contested_cycles: got %0d, want between %0d and 20000", cnt, T_SCROLL);
            n_fail++;
        end
        bad = scroll_errors(1'b0, 8'h41) + scroll_errors(1'b1, 8'h1E);
        n_cmp++;
        if (bad !== 0) begin
            $display("FAIL contested_maps: got %0d bad words, want 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic stray = 1'b0;
        cpu_write(A_CMD, 32'h2);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vga_bus.req, vga_bus.we, vga_bus.addr, vga_bus.wdata, cpu_bus.rdata, irq} !== '0) begin
            $display("FAIL reset_async: got req=%b addr=%h rdata=%h irq=%b, want all zero",
                     vga_bus.req, vga_bus.addr, cpu_bus.rdata, irq);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (vga_bus.req !== 1'b0) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            $display("FAIL reset_idle: got vga req after reset, want none");
            n_fail++;
        end
        cpu_read(A_CFG, d);
        n_cmp++;
        if (d !== 32'h0000_0F20) begin
            $display("FAIL reset_mid_cfg: got %h, want 00000f20", d);
            n_fail++;
        end
        cpu_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0) begin
            $display("FAIL reset_mid_status: got %h, want 0", d);
            n_fail++;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        cpu_bus.req   = 1'b0;
        cpu_bus.we    = 1'b0;
        cpu_bus.be    = 4'h0;
        cpu_bus.addr  = '0;
        cpu_bus.wdata = '0;
        test_reset();
        test_passthrough();
        test_cfg();
        test_clear();
        test_busy_cmd();
        test_scroll();
        test_contested();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
